// File: rtl/hconv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hconv_pkg
//  Description : Shared types and constants for the hconv feeder slice.
//  Revision    : 1.0  initial release
// ============================================================================
package hconv_pkg;

  // Width of every raster coordinate counter
  localparam int COORD_W = 16;

  // Feeder frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hconv_rc_ctr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hconv_rc_ctr
//  Description : Raster column/row counter. Column wraps at COLS-1 and bumps
//                the row; row wraps at ROWS-1. Synchronous clear has priority
//                over enable.
//  Revision    : 1.0  initial release
// ============================================================================
module hconv_rc_ctr
  import hconv_pkg::*;
#(
  parameter int COLS = 520,
  parameter int ROWS = 520
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_col,
  output logic [COORD_W-1:0] o_row,
  output logic               o_last
);

  localparam logic [COORD_W-1:0] c_col_max = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] c_row_max = COORD_W'(ROWS - 1);

  logic w_col_last;
  logic w_row_last;

  assign w_col_last = (o_col == c_col_max);
  assign w_row_last = (o_row == c_row_max);
  assign o_last     = w_col_last && w_row_last;

  // Advance the raster position, wrapping column into row and row into zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_col <= '0;
      o_row <= '0;
    end else if (i_clr) begin
      o_col <= '0;
      o_row <= '0;
    end else if (i_en) begin
      if (w_col_last) begin
        o_col <= '0;
        o_row <= w_row_last ? '0 : o_row + 1'b1;
      end else begin
        o_col <= o_col + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hconv_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hconv_feeder
//  Description : Raster pixel source for the hconvg8 convolver. Clears the
//                line buffers, streams one pixel per clock, appends LAT zero
//                flush samples and tags each convolver output with its frame
//                coordinate. Every output is registered: a sample launched
//                from STREAM/FLUSH state appears on hin the following cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module hconv_feeder
  import hconv_pkg::*;
#(
  parameter int HIM_LEN  = 520,
  parameter int HIM_ROWS = 520,
  parameter int HKER     = 3,
  parameter int LAT      = HIM_LEN + 2
) (
  input  logic                clk,
  input  logic                hres,
  input  logic                start,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [7:0]          hin,
  output logic                hclrbuffer,
  output logic [HKER-2:0]     hrowend,
  output logic                step,
  output logic                m_valid,
  output logic [COORD_W-1:0]  m_col,
  output logic [COORD_W-1:0]  m_row,
  output logic                busy,
  output logic                done,
  output logic                err_underrun
);

  localparam int                 FLUSH_W      = $clog2(LAT + 1);
  localparam logic [FLUSH_W-1:0] c_flush_last = FLUSH_W'(LAT - 1);
  localparam logic [31:0]        c_win_lo     = 32'(LAT);
  localparam logic [31:0]        c_win_hi     = 32'(LAT + HIM_LEN * HIM_ROWS);

  state_t               r_state;
  logic [FLUSH_W-1:0]   r_flush_cnt;
  logic [31:0]          r_emit_cnt;

  logic                 w_launch;
  logic                 w_in_win;
  logic                 w_in_last;
  logic [COORD_W-1:0]   w_ic;
  logic [COORD_W-1:0]   w_ir_unused;
  logic                 w_out_last;
  logic                 w_out_clr;
  logic                 w_out_en;
  logic [HKER-2:0]      w_mask;

  // A sample (real pixel or flush zero) leaves the feeder in these states
  assign w_launch = (r_state == ST_STREAM) || (r_state == ST_FLUSH);

  // Sample index r_emit_cnt falls inside the tagged output window
  assign w_in_win = (r_emit_cnt >= c_win_lo) && (r_emit_cnt < c_win_hi);

  // Output coordinate restarts at the first tagged sample, then steps once per
  // tagged sample; the last-flag guard keeps it parked on the final pixel.
  assign w_out_clr = w_launch && (r_emit_cnt == c_win_lo);
  assign w_out_en  = w_launch && (r_emit_cnt > c_win_lo) &&
                     (r_emit_cnt < c_win_hi) && !w_out_last;

  // Input-side position; keeps counting through FLUSH so the tap mask continues
  hconv_rc_ctr #(
    .COLS (HIM_LEN),
    .ROWS (HIM_ROWS)
  ) u_in_ctr (
    .clk    (clk),
    .rst    (hres),
    .i_clr  (r_state == ST_IDLE && start),
    .i_en   (w_launch),
    .o_col  (w_ic),
    .o_row  (w_ir_unused),
    .o_last (w_in_last)
  );

  // Output-side position drives the m_col/m_row ports directly
  hconv_rc_ctr #(
    .COLS (HIM_LEN),
    .ROWS (HIM_ROWS)
  ) u_out_ctr (
    .clk    (clk),
    .rst    (hres),
    .i_clr  (w_out_clr),
    .i_en   (w_out_en),
    .o_col  (m_col),
    .o_row  (m_row),
    .o_last (w_out_last)
  );

  // Tap mask: tap k is disabled on the column where it would reach across the row edge
  always_comb begin
    w_mask = '1;
    for (int k = 0; k < HKER - 1; k++) begin
      if (w_ic == COORD_W'(k)) begin
        w_mask[k] = 1'b0;
      end
    end
  end

  // Frame sequencer with registered convolver-side and status outputs
  always_ff @(posedge clk or posedge hres) begin
    if (hres) begin
      r_state      <= ST_IDLE;
      r_flush_cnt  <= '0;
      r_emit_cnt   <= '0;
      s_ready      <= 1'b0;
      hin          <= '0;
      hclrbuffer   <= 1'b0;
      hrowend      <= '0;
      step         <= 1'b0;
      m_valid      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      hclrbuffer <= 1'b0;
      done       <= 1'b0;

      if (w_launch) begin
        step       <= 1'b1;
        hin        <= (r_state == ST_STREAM && s_valid) ? s_data : 8'd0;
        hrowend    <= w_mask;
        m_valid    <= w_in_win;
        r_emit_cnt <= r_emit_cnt + 32'd1;
      end else begin
        step    <= 1'b0;
        hin     <= '0;
        hrowend <= '0;
        m_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_CLEAR;
            hclrbuffer   <= 1'b1;
            busy         <= 1'b1;
            err_underrun <= 1'b0;
            r_emit_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          r_state <= ST_STREAM;
          s_ready <= 1'b1;
        end
        ST_STREAM: begin
          if (!s_valid) begin
            err_underrun <= 1'b1;
          end
          if (w_in_last) begin
            r_state     <= ST_FLUSH;
            s_ready     <= 1'b0;
            r_flush_cnt <= '0;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == c_flush_last) begin
            r_state <= ST_DONE;
            done    <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
